// File: rtl/debounce_bank.sv
// Bank of independent debouncers: each raw input is synchronised, then must
// disagree with its accepted level for STABLE_CYCLES enabled cycles to be taken.
module debounce_bank #(
  parameter int CHANNELS      = 8,
  parameter int STABLE_CYCLES = 1000000,
  parameter int SYNC_STAGES   = 2,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw,
  input  logic                ce,
  input  logic                freeze,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_change
);

  localparam int                CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]     LAST    = CW'(STABLE_CYCLES - 1);
  localparam logic [CHANNELS-1:0] RST_VEC = {CHANNELS{RESET_LEVEL}};

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] sync;
  logic [CW-1:0]       cnt_q  [CHANNELS];
  logic [CW-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0] stable_d;
  logic [CHANNELS-1:0] rise_d;
  logic [CHANNELS-1:0] fall_d;

  // Synchronisers keep sampling even while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RST_VEC;
    end else begin
      sync_q[0] <= raw;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Freeze wins over everything, including the clear-on-match path.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (freeze) begin
        cnt_d[i] = cnt_q[i];
      end else if (sync[i] == stable[i]) begin
        cnt_d[i] = '0;
      end else if (ce) begin
        if (cnt_q[i] == LAST) begin
          stable_d[i] = sync[i];
          cnt_d[i]    = '0;
          rise_d[i]   = sync[i];
          fall_d[i]   = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      stable     <= RST_VEC;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      stable     <= stable_d;
      rise       <= rise_d;
      fall       <= fall_d;
      any_change <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus random traffic, checked every
// cycle against a rule-level reference model through an expected-value queue.
module tb_debounce_bank;

  localparam int CH = 4;
  localparam int SC = 4;
  localparam int SS = 2;
  localparam bit RL = 1'b0;
  localparam int W  = 3 * CH + 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] raw   = '0;
  logic          ce    = 1'b1;
  logic          freeze = 1'b0;
  logic [CH-1:0] stable, rise, fall;
  logic          any_change;

  int checks = 0;
  int fails  = 0;

  logic [W-1:0] exp_q[$];

  debounce_bank #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .SYNC_STAGES(SS), .RESET_LEVEL(RL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw(raw), .ce(ce), .freeze(freeze),
    .stable(stable), .rise(rise), .fall(fall), .any_change(any_change)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: raw history queue stands in for the synchroniser delay;
  // m_run counts enabled mismatch cycles since the level last matched.
  logic [CH-1:0] m_stable = {CH{RL}};
  int            m_run [CH];
  logic [CH-1:0] m_hist[$];

  function automatic void model_reset();
    m_stable = {CH{RL}};
    foreach (m_run[i]) m_run[i] = 0;
    m_hist.delete();
    for (int k = 0; k < SS; k++) m_hist.push_back({CH{RL}});
  endfunction

  function automatic logic [W-1:0] model_step(logic [CH-1:0] r_in, logic c_in, logic f_in);
    logic [CH-1:0] s, r, f;
    s = m_hist.pop_front();
    m_hist.push_back(r_in);
    r = '0;
    f = '0;
    if (!f_in) begin
      for (int i = 0; i < CH; i++) begin
        if (s[i] == m_stable[i]) m_run[i] = 0;
        else if (c_in) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_stable[i] = s[i];
            m_run[i]    = 0;
            if (s[i]) r[i] = 1'b1;
            else      f[i] = 1'b1;
          end
        end
      end
    end
    return {|(r | f), f, r, m_stable};
  endfunction

  initial model_reset();

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      exp_q.push_back(model_step(raw, ce, freeze));
    end
  end

  // Scoreboard monitor
  always @(posedge clk) begin
    logic [W-1:0] e, got;
    #1;
    got = {any_change, fall, rise, stable};
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_empty t=%0t got=%h exp=<none>", $time, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL sb_cycle t=%0t got={any,fall,rise,stable}=%h exp=%h", $time, got, e);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  initial begin
    // Reset with raw[0]=1 held across release
    raw = 4'h1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2 check("release_edge5_stable", W'(stable), W'(4'h0));
    @(posedge clk);
    #2 check("release_edge6", {any_change, rise, stable}, W'({1'b1, 4'h1, 4'h1}));
    @(posedge clk);
    #2 check("release_edge7_rise", W'(rise), W'(4'h0));

    // Three-cycle glitch on raw[1]
    @(negedge clk);
    raw = 4'h3;
    repeat (3) @(negedge clk);
    raw = 4'h1;
    repeat (8) @(negedge clk);
    check("glitch_stable", W'(stable), W'(4'h1));

    // Simultaneous fall on ch0 and rise on ch2
    raw = 4'h4;
    repeat (6) @(posedge clk);
    #2 check("simul_pulse", {any_change, fall, rise}, W'({1'b1, 4'h1, 4'h4}));
    @(posedge clk);
    #2 check("simul_pulse_off", {any_change, fall, rise}, W'(0));

    // ce alternating, enabled on even edges only
    @(negedge clk);
    raw = 4'hC;
    ce  = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #2;
      if (k == 9)  check("ce_half_edge9", W'(stable[3]), W'(1'b0));
      if (k == 10) check("ce_half_edge10", W'(stable[3]), W'(1'b1));
      @(negedge clk);
      ce = ~ce;
    end
    ce = 1'b1;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-count
    raw = 4'hD;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async_reset", {any_change, fall, rise, stable}, W'(0));
    @(negedge clk);
    raw = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Freeze mid-count from held count 2
    raw = 4'h1;
    repeat (4) @(negedge clk);
    freeze = 1'b1;
    repeat (10) @(negedge clk);
    freeze = 1'b0;
    @(posedge clk);
    #2 check("freeze_resume_1", {rise, stable}, W'({4'h0, 4'h0}));
    @(posedge clk);
    #2 check("freeze_resume_2", {rise, stable}, W'({4'h1, 4'h1}));

    // Random traffic: slow toggles, glitches, ce gaps, freeze, rare resets
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 9) == 0) raw[i] = ~raw[i];
      ce     = ($urandom_range(0, 7) != 0);
      freeze = ($urandom_range(0, 24) == 0);
      rst_n  = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    freeze = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter: CHANNELS, default 8, number of independent input channels (1..32).
REQ-002 Parameter: STABLE_CYCLES, default 1000000, number of consecutive enabled mismatch cycles required to accept a new level (>=1; 10 ms at 100 MHz).
REQ-003 Parameter: SYNC_STAGES, default 2, synchroniser depth per channel (>=2).
REQ-004 Parameter: RESET_LEVEL, default 0, reset value of every synchroniser flop and every stable bit.
REQ-005 Reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-006 clk  input  1  100 MHz system clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 raw  input  CHANNELS  noisy, asynchronous button/switch levels.
REQ-009 ce  input  1  sample enable; counters advance only when high.
REQ-010 freeze  input  1  holds all counters, stable bits and pulse outputs at idle.
REQ-011 stable  output  CHANNELS  debounced level per channel, registered.
REQ-012 rise  output  CHANNELS  one-cycle pulse when stable[i] goes 0->1, registered.
REQ-013 fall  output  CHANNELS  one-cycle pulse when stable[i] goes 1->0, registered.
REQ-014 any_change  output  1  one-cycle pulse, OR of all rise and fall bits in the same cycle, registered.

Function
REQ-015 Each channel SHALL pass raw[i] through a SYNC_STAGES-deep flop chain; sync[i] is the last stage.
REQ-016 Each channel SHALL own a counter of width $clog2(STABLE_CYCLES+1), with no sharing between channels.
REQ-017 On an edge where sync[i]==stable[i], counter[i] SHALL clear to 0, regardless of ce.
REQ-018 On an edge where sync[i]!=stable[i], ce=1, freeze=0 and counter[i]<STABLE_CYCLES-1, counter[i] SHALL increment by 1.
REQ-019 On an edge where sync[i]!=stable[i], ce=1, freeze=0 and counter[i]==STABLE_CYCLES-1, the channel SHALL:
  - load stable[i] from sync[i];
  - clear counter[i];
  - assert the matching rise[i] or fall[i] for exactly that following cycle.
REQ-020 With ce=0 and a mismatch present, counter[i] and stable[i] SHALL hold.
REQ-021 Latency with ce held at 1: a raw[i] level held from before edge 1 SHALL appear on stable[i] at edge SYNC_STAGES+STABLE_CYCLES.
REQ-022 A mismatch lasting fewer than STABLE_CYCLES enabled cycles (a glitch) SHALL leave stable[i] unchanged and produce no pulse.
REQ-023 rise, fall and any_change SHALL be 0 in every cycle without a qualifying transition; there SHALL be no back-to-back pulses on one channel.
REQ-024 Simultaneous transitions on several channels SHALL pulse all of them in the same cycle, with any_change high for that one cycle only.
REQ-025 freeze=1 SHALL:
  - hold counters and stable;
  - force rise, fall and any_change to 0;
  - let the synchronisers keep sampling.
REQ-026 After freeze deasserts, counting SHALL resume from the held counter values.
REQ-027 When STABLE_CYCLES=1, a new level SHALL be accepted on the first enabled mismatch edge.

Reset
REQ-028 While rst_n=0, without waiting for clk, the block SHALL force:
  - synchroniser flops and stable to {CHANNELS{RESET_LEVEL}};
  - counters to 0;
  - rise, fall and any_change to 0.
REQ-029 Reset assertion mid-count SHALL abort the count with no pulse.
REQ-030 Release of reset SHALL produce no pulse unless raw differs from RESET_LEVEL for the full debounce time.

Verification (CHANNELS=4, STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0, ce=1, freeze=0 unless stated)
REQ-031 Reset with raw=4'h1 held across release -> stable=4'h0 through edge 5; stable[0]=1 and rise=4'h1 at edge 6; rise=0 at edge 7.
REQ-032 raw[1] high for 3 cycles, then low -> stable[1] stays 0; rise, fall and any_change stay 0 throughout.
REQ-033 From stable=4'h1: raw[0]->0 and raw[2]->1 in the same cycle -> 6 edges later fall=4'h1, rise=4'h4 and any_change=1, all for exactly one cycle.
REQ-034 ce toggling 1,0,1,0 with raw[3]->1 -> stable[3] rises at edge 2+8=10, not edge 6.
REQ-035 rst_n pulled low between clk edges at counter=2 -> counters, stable and pulses read 0 before the next clk edge; no pulse after release with raw=0.
REQ-036 freeze=1 for 10 cycles mid-count with raw[0] held 1 -> stable[0] holds 0 and no pulses; stable[0] rises 2 enabled edges after freeze drops, from held count 2.
